// File: rtl/booth_arb_pkg.sv
// Shared defaults, id-width helper and result FIFO entry type for booth_mult_arbiter.
package booth_arb_pkg;
    localparam int N_DEF          = 8;
    localparam int NREQ_DEF       = 4;
    localparam int MUL_LAT_DEF    = 3;
    localparam int FIFO_DEPTH_DEF = 5;

    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = id_w(NREQ_DEF);

    typedef struct packed {
        logic signed [2*N_DEF-1:0] data;
        logic [ID_W_DEF-1:0]       id;
    } res_entry_t;
endpackage

// File: rtl/booth_mult_arbiter_if.sv
// Request, multiplier and result buses of booth_mult_arbiter.
interface booth_mult_arbiter_if #(
    parameter int N    = booth_arb_pkg::N_DEF,
    parameter int NREQ = booth_arb_pkg::NREQ_DEF
);
    import booth_arb_pkg::*;
    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*N-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic signed [N-1:0] mul_a;
    logic signed [N-1:0] mul_b;
    logic signed [2*N-1:0] mul_prod;
    logic                res_valid;
    logic                res_ready;
    logic signed [2*N-1:0] res_data;
    logic [IDW-1:0]      res_id;

    modport slave (
        input  req_valid, req_a, req_b, mul_prod, res_ready,
        output req_ready, mul_a, mul_b, res_valid, res_data, res_id
    );
    modport master (
        output req_valid, req_a, req_b, mul_prod, res_ready,
        input  req_ready, mul_a, mul_b, res_valid, res_data, res_id
    );
endinterface

// File: rtl/booth_arb_fifo.sv
// First-word fall-through result FIFO; head reads as zero while empty.
module booth_arb_fifo
    import booth_arb_pkg::*;
#(
    parameter int  DEPTH   = FIFO_DEPTH_DEF,
    parameter type entry_t = res_entry_t
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_push,
    input  entry_t i_wdata,
    input  logic   i_pop,
    output entry_t o_rdata,
    output logic   o_full,
    output logic   o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= nxt(r_wptr);
            if (w_pop)  r_rptr <= nxt(r_rptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one external pipelined Booth multiplier.
// Statistics counters are built only when BOOTH_ARB_STATS_EN is defined.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int NREQ       = NREQ_DEF,
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    booth_mult_arbiter_if.slave bus,
    output logic        o_busy,
    output logic [31:0] o_stat_issued,
    output logic [31:0] o_stat_stall
);
    localparam int IDW = id_w(NREQ);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic signed [2*N-1:0] data;
        logic [IDW-1:0]        id;
    } entry_t;

    logic [CW-1:0]              r_cnt;
    logic [IDW-1:0]             r_ptr;
    logic signed [N-1:0]        r_mul_a, r_mul_b;
    // Index 0 lines up with the operand registers, index MUL_LAT with mul_prod.
    logic [MUL_LAT:0]           r_vld_pipe;
    logic [MUL_LAT:0][IDW-1:0]  r_id_pipe;

    logic                       w_credit, w_found, w_issue, w_pop;
    logic                       w_full, w_empty;
    logic [IDW:0]               w_sum;
    logic [IDW-1:0]             w_gnt_idx;
    logic [NREQ-1:0]            w_gnt;
    logic [CW-1:0]              w_count;
    entry_t                     w_wdata, w_rdata;

    assign w_credit = !i_rst && (r_cnt < CW'(FIFO_DEPTH));

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
            if (!w_found && bus.req_valid[w_sum[IDW-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_sum[IDW-1:0];
            end
        end
        w_gnt = '0;
        if (w_found && w_credit) w_gnt[w_gnt_idx] = 1'b1;
    end

    assign bus.req_ready = w_gnt;
    assign w_issue       = |w_gnt;
    assign w_pop         = !w_empty && bus.res_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
        end else begin
            r_mul_a    <= w_issue ? $signed(bus.req_a[int'(w_gnt_idx)*N +: N]) : '0;
            r_mul_b    <= w_issue ? $signed(bus.req_b[int'(w_gnt_idx)*N +: N]) : '0;
            r_vld_pipe <= {r_vld_pipe[MUL_LAT-1:0], w_issue};
            r_id_pipe  <= {r_id_pipe[MUL_LAT-1:0], w_gnt_idx};
            r_cnt      <= r_cnt + CW'(w_issue) - CW'(w_pop);
            if (w_issue)
                r_ptr <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
        end
    end

    assign bus.mul_a = r_mul_a;
    assign bus.mul_b = r_mul_b;
    assign w_wdata   = '{data: bus.mul_prod, id: r_id_pipe[MUL_LAT]};

    booth_arb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_vld_pipe[MUL_LAT] && !w_full),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.res_valid = !w_empty;
    assign bus.res_data  = w_rdata.data;
    assign bus.res_id    = w_rdata.id;
    assign o_busy        = (|r_vld_pipe) || (w_count != '0);

`ifdef BOOTH_ARB_STATS_EN
    logic [31:0] r_stat_issued, r_stat_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_issue && r_stat_issued != '1) r_stat_issued <= r_stat_issued + 32'd1;
            if ((|bus.req_valid) && !w_credit && r_stat_stall != '1)
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign o_stat_issued = r_stat_issued;
    assign o_stat_stall  = r_stat_stall;
`else
    assign o_stat_issued = '0;
    assign o_stat_stall  = '0;
`endif
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a 3-stage behavioural multiplier.
module tb_booth_mult_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [31:0] stat_issued, stat_stall;

    always #5 clk = ~clk;

    booth_mult_arbiter_if #(.N(8), .NREQ(4)) bus ();

    booth_mult_arbiter #(.N(8), .NREQ(4), .MUL_LAT(3), .FIFO_DEPTH(5)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus.slave),
        .o_busy        (busy),
        .o_stat_issued (stat_issued),
        .o_stat_stall  (stat_stall)
    );

    // Free-running multiplier, never reset, so stale products keep flowing.
    logic signed [15:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= bus.mul_a * bus.mul_b;
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.mul_prod = p3;

    // Requester operands and hand-computed products.
    logic [7:0]  a_tab [4] = '{8'h80, 8'h03, 8'h07, 8'h7F};
    logic [7:0]  b_tab [4] = '{8'h80, 8'h05, 8'hFD, 8'h80};
    logic [15:0] p_tab [4] = '{16'h4000, 16'h000F, 16'hFFEB, 16'hC080};

    // Expected grants for 17 cycles of all-valid traffic with res_ready=1.
    logic [3:0] rr_exp [17] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000,
                                4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000,
                                4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  id;
    } exp_t;
    exp_t sb [$];

    int n_chk = 0;
    int n_err = 0;
    int n_issue = 0;
    int n_pop = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int max);
        int k = 0;
        while (busy && k < max) begin
            tick();
            k++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    // Scoreboard: grants push the hand-computed product, result handshakes pop.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.res_valid && bus.res_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_data", 32'($unsigned(bus.res_data)), 32'(e.data));
                    chk("res_id", 32'(bus.res_id), 32'(e.id));
                end
            end
            if (|bus.req_ready) begin
                n_issue++;
                chk("grant_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                for (int i = 0; i < 4; i++)
                    if (bus.req_ready[i]) sb.push_back('{data: p_tab[i], id: 2'(i)});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_i, base_p, nb;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        bus.req_a     = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
        bus.req_b     = {b_tab[3], b_tab[2], b_tab[1], b_tab[0]};
        repeat (2) tick();
        rst = 1'b0;
        #1;

        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mul_a", 32'($unsigned(bus.mul_a)), 32'd0);
        chk("rst_mul_b", 32'($unsigned(bus.mul_b)), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", 32'($unsigned(bus.res_data)), 32'd0);
        chk("rst_res_id", 32'(bus.res_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ptr", 32'(dut.r_ptr), 32'd0);
        chk("rst_stat_issued", stat_issued, 32'd0);
        chk("rst_stat_stall", stat_stall, 32'd0);

        // Single request from requester 2: 7 * -3.
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b0100;
        #1;
        chk("single_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        #1;
        chk("single_mul_a", 32'($unsigned(bus.mul_a)), 32'h07);
        chk("single_mul_b", 32'($unsigned(bus.mul_b)), 32'hFD);
        for (int c = 1; c < 5; c++) begin
            chk($sformatf("single_no_valid_c%0d", c), 32'(bus.res_valid), 32'd0);
            tick();
        end
        chk("single_valid_c5", 32'(bus.res_valid), 32'd1);
        chk("single_data", 32'($unsigned(bus.res_data)), 32'hFFEB);
        chk("single_id", 32'(bus.res_id), 32'd2);
        tick();
        chk("single_done_valid", 32'(bus.res_valid), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);

        // Round-robin with all requesters valid and the consumer always ready.
        do_reset();
        base_i = n_issue;
        base_p = n_pop;
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            #1;
            chk($sformatf("rr_grant_c%0d", c), 32'(bus.req_ready), 32'(rr_exp[c]));
            if (c == 5) chk("full_cnt_c5", 32'(dut.r_cnt), 32'd5);
            if (c == 5) chk("full_pop_c5", 32'(bus.res_valid), 32'd1);
            if (c == 6) chk("full_cnt_c6", 32'(dut.r_cnt), 32'd4);
            if (c == 7) chk("full_cnt_c7", 32'(dut.r_cnt), 32'd4);
            tick();
        end
        bus.req_valid = '0;
        drain(20);
        chk("rr_issues", 32'(n_issue - base_i), 32'd15);
        chk("rr_results", 32'(n_pop - base_p), 32'd15);
        chk("rr_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: consumer stalled, credits run out after five issues.
        do_reset();
        base_p = n_pop;
        bus.req_valid = 4'b1111;
        nb = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (|bus.req_ready) nb++;
            tick();
        end
        chk("bp_issue_count", 32'(nb), 32'd5);
        chk("bp_no_grant", 32'(bus.req_ready), 32'd0);
        chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
        chk("bp_head_id", 32'(bus.res_id), 32'd0);
`ifdef BOOTH_ARB_STATS_EN
        chk("bp_stat_issued", stat_issued, 32'd5);
        chk("bp_stat_stall", stat_stall, 32'd5);
`else
        chk("bp_stat_issued_off", stat_issued, 32'd0);
        chk("bp_stat_stall_off", stat_stall, 32'd0);
`endif
        bus.res_ready = 1'b1;
        #1;
        chk("bp_pop_cycle_no_issue", 32'(bus.req_ready), 32'd0);
        tick();
        chk("bp_resume_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        drain(20);
        chk("bp_results", 32'(n_pop - base_p), 32'd6);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Reset with three products in flight and two waiting in the FIFO.
        do_reset();
        bus.req_valid = 4'b1111;
        repeat (6) tick();
        bus.req_valid = '0;
        chk("mid_pre_valid", 32'(bus.res_valid), 32'd1);
        chk("mid_pre_cnt", 32'(dut.r_cnt), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ptr", 32'(dut.r_ptr), 32'd0);
        bus.res_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.res_valid) nb++;
            tick();
        end
        chk("mid_no_stale", 32'(nb), 32'd0);
        bus.req_valid = 4'b1111;
        #1;
        chk("mid_grant_from_zero", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        drain(20);
        chk("mid_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
